// File: rtl/glyph_row_sequencer.sv
// Purpose : walks a latched ASCII string row-major through a shared 6x6 glyph ROM,
//           emitting one 6-pixel row slice per character per glyph row.
// Latency : zero added latency; glyph_char/out_bits follow the registered row/col in the same cycle.
// Backpr. : valid/ready on both sides; out_ready=0 freezes indices and outputs, req_ready only in IDLE.
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   req_valid/ready  render request handshake; req_len chars of req_chars (char 0 in [7:0])
//   glyph_char       ROM address (0 while idle); glyph_bitmap is the ROM's 6 rows of 6 bits
//   out_valid/ready  slice handshake; out_bits (bit 0 = leftmost pixel), out_row, out_col, out_last
//   done             one-cycle pulse after the final slice (or after a zero-length request)
//   stall_cnt        only with GLYPH_SEQ_STALL_CNT_EN: saturating count of stalled slice cycles
//
// Configuration: define GLYPH_SEQ_STALL_CNT_EN to add the stall_cnt port and counter.

module glyph_row_sequencer #(
  parameter  int MAX_CHARS = 8,
  localparam int LEN_W     = $clog2(MAX_CHARS + 1),
  localparam int COL_W     = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [LEN_W-1:0]       req_len,
  input  logic [8*MAX_CHARS-1:0] req_chars,
  output logic [7:0]             glyph_char,
  input  logic [5:0][5:0]        glyph_bitmap,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_bits,
  output logic [2:0]             out_row,
  output logic [COL_W-1:0]       out_col,
  output logic                   out_last,
  output logic                   done
`ifdef GLYPH_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic [2:0] LAST_ROW = 3'd5;

  state_t                       r_state;
  logic [MAX_CHARS-1:0][7:0]    r_chars;
  logic [LEN_W-1:0]             r_len;
  logic [2:0]                   r_row;
  logic [COL_W-1:0]             r_col;
  logic                         r_done;

  logic                         w_scan;
  logic                         w_accept;
  logic                         w_fire;
  logic [LEN_W-1:0]             w_len_clamped;
  logic [LEN_W:0]               w_col_plus1;
  logic                         w_col_last;
  logic                         w_row_last;

  assign w_scan = (r_state == S_SCAN);

  // Gating req_ready with rst keeps a request presented during reset from
  // looking accepted on the interface while the state machine ignores it.
  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;
  assign w_fire    = w_scan && out_ready;

  assign w_len_clamped = (req_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : req_len;

  // Compare col+1 against len in a width one bit wider than len so the test
  // cannot wrap, whatever MAX_CHARS is.
  assign w_col_plus1 = {{(LEN_W + 1 - COL_W){1'b0}}, r_col} + {{LEN_W{1'b0}}, 1'b1};
  assign w_col_last  = (w_col_plus1 == {1'b0, r_len});
  assign w_row_last  = (r_row == LAST_ROW);

  // Slice outputs are decoded straight from the registered indices so the
  // ROM lookup adds no cycle; everything is forced to zero while idle.
  assign out_valid  = w_scan;
  assign glyph_char = w_scan ? r_chars[r_col] : 8'h00;
  assign out_bits   = w_scan ? glyph_bitmap[r_row] : 6'h00;
  assign out_row    = w_scan ? r_row : 3'd0;
  assign out_col    = w_scan ? r_col : '0;
  assign out_last   = w_scan && w_row_last && w_col_last;
  assign done       = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_chars <= '0;
      r_len   <= '0;
      r_row   <= 3'd0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_chars <= req_chars;
            r_len   <= w_len_clamped;
            r_row   <= 3'd0;
            r_col   <= '0;
            // Empty request: nothing to scan, completion is signalled at once.
            if (w_len_clamped == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (w_fire) begin
            if (w_col_last) begin
              r_col <= '0;
              if (w_row_last) begin
                // Final slice taken: req_ready can only rise next cycle.
                r_state <= S_IDLE;
                r_row   <= 3'd0;
                r_done  <= 1'b1;
              end else begin
                r_row <= r_row + 3'd1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GLYPH_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_accept) begin
      r_stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
